// File: rtl/fft_frame_sink.sv
// fft_frame_sink: ping-pong frame buffer between an FFT output stream and a
// ready/valid consumer. Two banks of N complex samples; one fills while the
// other drains. A frame whose target bank is still occupied is dropped whole
// and the sticky overflow flag is raised.
// Optional macro DIGIT_REVERSE_EN: read each frame in radix-4 digit-reversed
// address order so a radix-4 SDF output comes out in natural bin order.
module fft_frame_sink #(
  parameter int WIDTH = 32,
  parameter int N     = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_en,
  input  logic signed [WIDTH-1:0] in_real,
  input  logic signed [WIDTH-1:0] in_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_real,
  output logic signed [WIDTH-1:0] out_imag,
  output logic [$clog2(N)-1:0]    out_index,
  output logic                    out_last,
  output logic                    overflow
);
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_DRAINING} bank_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_SEND} rd_state_t;

  // Bank b occupies addresses {b, idx}
  logic [2*WIDTH-1:0] mem [0:2*N-1];

  bank_state_t        bank_state_q [2];
  bank_state_t        bank_state_d [2];
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic               wr_bank_q, wr_bank_d;
  logic               wr_drop_q, wr_drop_d;
  logic               overflow_q, overflow_d;
  rd_state_t          rd_state_q, rd_state_d;
  logic               rd_bank_q, rd_bank_d;
  logic               out_valid_q, out_valid_d;
  logic [IDX_W-1:0]   out_index_q, out_index_d;
  logic               out_last_q, out_last_d;
  logic [2*WIDTH-1:0] out_data_q;

  logic               mem_we;
  logic [IDX_W:0]     mem_waddr;
  logic [2*WIDTH-1:0] mem_wdata;
  logic               rd_load;
  logic [IDX_W-1:0]   rd_sel_idx;
  logic [IDX_W-1:0]   next_idx;
  logic               other_bank;
  logic [IDX_W:0]     rd_addr;

  // Output position k -> stored position (identity, or base-4 digit reversal)
  function automatic logic [IDX_W-1:0] map_index(input logic [IDX_W-1:0] k);
`ifdef DIGIT_REVERSE_EN
    logic [IDX_W-1:0] r;
    r = '0;
    for (int d = 0; d < IDX_W / 2; d++) begin
      r[2*d +: 2] = k[IDX_W-2-2*d +: 2];
    end
    return r;
`else
    return k;
`endif
  endfunction

  assign rd_addr = {rd_bank_q, map_index(rd_sel_idx)};

  // Next-state logic: write pointer and frame admission, bank states, read FSM
  always_comb begin
    wr_idx_d     = wr_idx_q;
    wr_bank_d    = wr_bank_q;
    wr_drop_d    = wr_drop_q;
    overflow_d   = overflow_q;
    bank_state_d = bank_state_q;
    mem_we       = 1'b0;
    mem_waddr    = {wr_bank_q, wr_idx_q};
    mem_wdata    = {in_real, in_imag};
    rd_state_d   = rd_state_q;
    rd_bank_d    = rd_bank_q;
    out_valid_d  = out_valid_q;
    out_index_d  = out_index_q;
    out_last_d   = out_last_q;
    rd_load      = 1'b0;
    rd_sel_idx   = '0;
    next_idx     = out_index_q + 1'b1;
    other_bank   = ~rd_bank_q;

    // Write side only touches EMPTY/FILLING banks, read side only FULL/DRAINING,
    // so both may update bank_state_d in the same cycle without conflict.
    if (in_en) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_idx_q == '0) begin
        if (bank_state_q[wr_bank_q] == BANK_EMPTY) begin
          bank_state_d[wr_bank_q] = BANK_FILLING;
          wr_drop_d               = 1'b0;
          mem_we                  = 1'b1;
        end else begin
          // Whole frame is discarded; the write bank stays put so banks keep alternating in frame order
          wr_drop_d  = 1'b1;
          overflow_d = 1'b1;
        end
      end else if (!wr_drop_q) begin
        mem_we = 1'b1;
        if (wr_idx_q == LAST_IDX) begin
          bank_state_d[wr_bank_q] = BANK_FULL;
          wr_bank_d               = ~wr_bank_q;
        end
      end
    end

    case (rd_state_q)
      RD_IDLE: begin
        if (bank_state_q[rd_bank_q] == BANK_FULL) begin
          bank_state_d[rd_bank_q] = BANK_DRAINING;
          rd_state_d              = RD_LOAD;
        end
      end
      RD_LOAD: begin
        rd_load     = 1'b1;
        out_valid_d = 1'b1;
        out_index_d = '0;
        out_last_d  = 1'b0;
        rd_state_d  = RD_SEND;
      end
      RD_SEND: begin
        if (out_ready) begin
          if (out_last_q) begin
            // Free this bank and, if the other is already waiting, claim it now
            bank_state_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d               = other_bank;
            out_valid_d             = 1'b0;
            out_last_d              = 1'b0;
            out_index_d             = '0;
            if (bank_state_q[other_bank] == BANK_FULL) begin
              bank_state_d[other_bank] = BANK_DRAINING;
              rd_state_d               = RD_LOAD;
            end else begin
              rd_state_d = RD_IDLE;
            end
          end else begin
            rd_load     = 1'b1;
            rd_sel_idx  = next_idx;
            out_index_d = next_idx;
            out_last_d  = (next_idx == LAST_IDX);
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Per-bank state registers
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    always_ff @(posedge clock or posedge reset) begin
      if (reset) bank_state_q[gi] <= BANK_EMPTY;
      else       bank_state_q[gi] <= bank_state_d[gi];
    end
  end

  // Sample storage; contents survive reset
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered read of the bank memory into the output sample register
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        out_data_q <= '0;
    else if (rd_load) out_data_q <= mem[rd_addr];
  end

  // Control registers; reset returns both sides to bank 0 and clears outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      wr_drop_q   <= 1'b0;
      overflow_q  <= 1'b0;
      rd_state_q  <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      wr_drop_q   <= wr_drop_d;
      overflow_q  <= overflow_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;
  assign out_real  = out_data_q[2*WIDTH-1:WIDTH];
  assign out_imag  = out_data_q[WIDTH-1:0];

endmodule

// File: tb/tb_fft_frame_sink.sv
// Testbench for fft_frame_sink (N=16, WIDTH=32). Honours DIGIT_REVERSE_EN
// when the macro is defined for the whole build.
module tb_fft_frame_sink;
  localparam int WIDTH = 32;
  localparam int N     = 16;
  localparam int IDX_W = 4;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    in_en = 1'b0;
  logic signed [WIDTH-1:0] in_real = '0;
  logic signed [WIDTH-1:0] in_imag = '0;
  logic                    out_ready = 1'b0;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_real;
  logic signed [WIDTH-1:0] out_imag;
  logic [IDX_W-1:0]        out_index;
  logic                    out_last;
  logic                    overflow;

  fft_frame_sink #(.WIDTH(WIDTH), .N(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_en    (in_en),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_real (out_real),
    .out_imag (out_imag),
    .out_index(out_index),
    .out_last (out_last),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, $time, $signed(act), act, $signed(exp), exp);
  endtask

  // ---------------- behavioural model ----------------
  // Frames are whole objects: at most two may be held (filling, waiting or
  // draining). A frame leaves the buffer on its last transfer.
  logic [63:0] fdata [0:63][0:15];
  int          fdone [0:63];
  int          fq[$];
  int          cyc       = 0;
  int          m_widx    = 0;
  int          cur_fid   = 0;
  int          next_fid  = 0;
  int          last_end  = -100;
  int          exp_idx   = 0;
  bit          m_drop    = 1'b0;
  bit          m_ovf     = 1'b0;
  bit          exp_valid = 1'b0;
  logic [63:0] exp_word;

  function automatic int map_pos(input int k);
`ifdef DIGIT_REVERSE_EN
    int r = 0;
    int v = k;
    for (int d = 0; d < IDX_W / 2; d++) begin
      r = r * 4 + v % 4;
      v = v / 4;
    end
    return r;
`else
    return k;
`endif
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      fq.delete();
      m_widx = 0; m_drop = 1'b0; m_ovf = 1'b0;
      exp_valid = 1'b0; exp_idx = 0; last_end = -100;
    end else begin
      if (in_en) begin
        if (m_widx == 0) begin
          if (fq.size() < 2) begin
            m_drop = 1'b0;
            cur_fid = next_fid;
            next_fid = (next_fid + 1) % 64;
            fdone[cur_fid] = -1;
            fq.push_back(cur_fid);
          end else begin
            m_drop = 1'b1;
            m_ovf  = 1'b1;
          end
        end
        if (!m_drop) begin
          fdata[cur_fid][m_widx] = {in_real, in_imag};
          if (m_widx == N - 1) fdone[cur_fid] = cyc;
        end
        m_widx = (m_widx + 1) % N;
      end
      if (exp_valid) begin
        if (out_ready) begin
          if (exp_idx == N - 1) begin
            void'(fq.pop_front());
            exp_valid = 1'b0;
            exp_idx = 0;
            last_end = cyc;
          end else begin
            exp_idx++;
          end
        end
      end else if (fq.size() > 0) begin
        // Output begins 2 edges after the frame completes and never sooner
        // than one idle cycle after the previous frame's last transfer.
        if (fdone[fq[0]] >= 0 && cyc >= fdone[fq[0]] + 2 && cyc >= last_end + 1) begin
          exp_valid = 1'b1;
          exp_idx = 0;
        end
      end
    end
    cyc++;
  end

  // Per-cycle compare of DUT outputs against the model
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      check("valid", 32'(out_valid), 32'(exp_valid));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (exp_valid) begin
        exp_word = fdata[fq[0]][map_pos(exp_idx)];
        check("index", 32'(out_index), 32'(exp_idx));
        check("real", out_real, exp_word[63:32]);
        check("imag", out_imag, exp_word[31:0]);
        check("last", 32'(out_last), 32'(exp_idx == N - 1));
      end
    end
  end

  // ---------------- stimulus ----------------
  int          rdy_mode = 0;   // 0: ready=1, 1: random, 2: ready=0, 3: manual
  int          xfer_cnt = 0;
  int          low_run  = 0;
  int          last_gap = 0;
  bit          seen_v   = 1'b0;
  logic [63:0] cap [0:15];

  task automatic meas_clear();
    xfer_cnt = 0; low_run = 0; last_gap = 0; seen_v = 1'b0;
  endtask

  task automatic tick();
    @(negedge clock);
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: out_ready = 1'b0;
      default: ;
    endcase
    if (out_valid && out_ready) begin
      xfer_cnt++;
      cap[out_index] = {out_real, out_imag};
    end
    if (out_valid) begin
      if (seen_v && low_run > 0) last_gap = low_run;
      low_run = 0;
      seen_v = 1'b1;
    end else if (seen_v) begin
      low_run++;
    end
  endtask

  // kind 0: real = tag*1000 + 10*i, imag = -(tag*1000 + i); kind 1: random
  task automatic send_frame(input int kind, input int tag, input int gap_pct);
    for (int i = 0; i < N; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        tick();
        in_en = 1'b0;
      end
      tick();
      in_en = 1'b1;
      if (kind == 0) begin
        in_real = 32'(tag * 1000 + 10 * i);
        in_imag = 32'(-(tag * 1000 + i));
      end else begin
        in_real = $urandom;
        in_imag = $urandom;
      end
    end
    tick();
    in_en = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((fq.size() != 0 || exp_valid) && n < max) begin
      tick();
      n++;
    end
    check("idle_within_budget", 32'(n < max), 32'd1);
  endtask

  task automatic wait_index(input int idx, input int max);
    int n = 0;
    while (!(out_valid && out_index == IDX_W'(idx)) && n < max) begin
      tick();
      n++;
    end
    check("index_reached_within_budget", 32'(n < max), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_real", out_real, 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Pattern frame: latency and known bin values
    rdy_mode = 0;
    meas_clear();
    send_frame(0, 0, 0);
    check("lat_k0_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_k1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_k2_valid", 32'(out_valid), 32'd1);
    wait_idle(200);
`ifdef DIGIT_REVERSE_EN
    check("bin1_real", cap[1][63:32], 32'd40);
    check("bin1_imag", cap[1][31:0], -32'sd4);
    check("bin6_real", cap[6][63:32], 32'd90);
    check("bin6_imag", cap[6][31:0], -32'sd9);
`else
    check("bin1_real", cap[1][63:32], 32'd10);
    check("bin1_imag", cap[1][31:0], -32'sd1);
    check("bin6_real", cap[6][63:32], 32'd60);
    check("bin6_imag", cap[6][31:0], -32'sd6);
`endif
    check("bin15_real", cap[15][63:32], 32'd150);
    check("bin15_imag", cap[15][31:0], -32'sd15);
    check("frame1_xfers", 32'(xfer_cnt), 32'd16);

    // Back-to-back frames
    meas_clear();
    send_frame(0, 1, 0);
    send_frame(0, 2, 0);
    wait_idle(200);
    check("b2b_xfers", 32'(xfer_cnt), 32'd32);
    check("b2b_gap", 32'(last_gap), 32'd1);
    check("b2b_overflow", 32'(overflow), 32'd0);

    // Stall at index 7 for 5 cycles
    send_frame(0, 0, 0);
    wait_index(7, 100);
    rdy_mode = 3;
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_index", 32'(out_index), 32'd7);
`ifdef DIGIT_REVERSE_EN
      check("stall_real", out_real, 32'd130);
      check("stall_imag", out_imag, -32'sd13);
`else
      check("stall_real", out_real, 32'd70);
      check("stall_imag", out_imag, -32'sd7);
`endif
    end
    out_ready = 1'b1;
    tick();
    check("resume_index", 32'(out_index), 32'd8);
`ifdef DIGIT_REVERSE_EN
    check("resume_real", out_real, 32'd20);
`else
    check("resume_real", out_real, 32'd80);
`endif
    rdy_mode = 0;
    wait_idle(200);

    // Three frames while ready=0: third is dropped
    meas_clear();
    rdy_mode = 2;
    send_frame(0, 1, 0);
    send_frame(0, 2, 0);
    send_frame(0, 3, 0);
    check("ovf_set", 32'(overflow), 32'd1);
    rdy_mode = 0;
    wait_idle(200);
    check("ovf_xfers", 32'(xfer_cnt), 32'd32);
    check("ovf_lastframe_b0", cap[0][63:32], 32'd2000);
    check("ovf_lastframe_b15", cap[15][63:32], 32'd2150);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a drain
    send_frame(0, 5, 0);
    wait_index(5, 100);
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_last", 32'(out_last), 32'd0);
    check("midrst_index", 32'(out_index), 32'd0);
    check("midrst_real", out_real, 32'd0);
    check("midrst_imag", out_imag, 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    tick();
    reset = 1'b0;
    meas_clear();
    send_frame(0, 6, 0);
    wait_idle(200);
    check("postrst_xfers", 32'(xfer_cnt), 32'd16);
    check("postrst_b0", cap[0][63:32], 32'd6000);
    check("postrst_overflow", 32'(overflow), 32'd0);

    // Random traffic: random data, input gaps and back-pressure
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      send_frame(1, f, 20);
      repeat ($urandom_range(0, 25)) tick();
    end
    rdy_mode = 0;
    wait_idle(2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_frame_sink.md
FFT_FRAME_SINK -- requirements
Module: fft_frame_sink

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, sample component width; N, default 16, frame length (power of 4, 16..1024).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_en  input  1  input sample valid; connects to the FFT output_en.
REQ-005 in_real / in_imag  input  WIDTH each  signed sample; connect to FFT output_real/output_imag.
REQ-006 out_valid  output  1  output sample valid.
REQ-007 out_ready  input  1  downstream accept.
REQ-008 out_real / out_imag  output  WIDTH each  signed output sample.
REQ-009 out_index  output  log2(N)  natural-order bin index of the current output sample.
REQ-010 out_last  output  1  high with out_index = N-1.
REQ-011 overflow  output  1  sticky frame-drop flag.

Function
REQ-012 Two banks (ping-pong), N entries of {real, imag} each; each bank state is EMPTY, FILLING, FULL or DRAINING.
REQ-013 Write: every clock edge with in_en=1 stores the sample at wr_idx in the write bank and increments wr_idx; in_en=0 holds wr_idx, so gaps inside a frame are legal.
REQ-014 wr_idx wraps N-1 -> 0; on the edge that stores sample N-1, the write bank becomes FULL and the write pointer moves to the other bank.
REQ-015 If the target bank is not EMPTY when sample 0 of a frame arrives, the whole frame is discarded (wr_idx still counts 0..N-1 to keep alignment) and overflow is set to 1 and remains set until reset.
REQ-016 Read: when a bank is FULL and the read side is idle, that bank goes to DRAINING; out_valid rises exactly 2 cycles after the edge that stored sample N-1 (edge k stores it, out_valid is high after edge k+2).
REQ-017 Transfer occurs on an edge with out_valid=1 and out_ready=1; out_index then advances by 1; while out_ready=0, all out_* outputs SHALL hold stable.
REQ-018 After the out_last transfer, the bank becomes EMPTY and out_valid is low for exactly one cycle; it then rises if the other bank is FULL.
REQ-019 Simultaneous events: a write completing into one bank on the same edge as the last read of the other bank SHALL lose no data; a bank freed on edge e is writable from edge e+1.
REQ-020 Output data is registered from bank memory; no combinational path runs from in_* to out_*.
REQ-021 Frames are emitted in arrival order; data values are passed through bit-exact with no arithmetic.

Reset
REQ-022 Asserting reset SHALL immediately force out_valid=0, out_last=0, out_index=0, out_real=0, out_imag=0 and overflow=0.
REQ-023 Asserting reset SHALL set both banks EMPTY and wr_idx=0, and select bank 0 for both write and read.
REQ-024 Reset mid-frame or mid-drain discards all buffered data; the first frame after reset starts at wr_idx=0.
REQ-025 Memory contents need not be cleared.

Configuration
REQ-026 Macro DIGIT_REVERSE_EN defined: output sample k SHALL be read from stored position digitrev4(k), where the log4(N) base-4 digits of k are reversed (N=16: 1->4, 2->8, 6->9, 7->13). This converts radix-4 SDF digit-reversed output to natural order.
REQ-027 DIGIT_REVERSE_EN undefined: output sample k SHALL be read from stored position k (arrival order). out_index still counts 0..N-1.

Verification
REQ-028 N=16, ready=1, one frame with in_real=10*i, in_imag=-i for i=0..15 -> with DIGIT_REVERSE_EN, out_index 1 gives (40,-4), index 6 gives (90,-9), index 15 gives (150,-15). Without the macro, index 1 gives (10,-1).
REQ-029 Last input sample stored on edge k -> out_valid is first high after edge k+2, and out_last is high at index 15 only.
REQ-030 Two back-to-back frames with ready=1 -> 32 transfers, exactly one idle cycle between frames, overflow=0.
REQ-031 ready held low for 5 cycles at out_index=7 -> out_real, out_imag, out_index and out_valid are unchanged across those cycles; the sequence resumes at index 8.
REQ-032 ready=0 while 3 frames (A, B, C) arrive -> overflow=1; after ready=1, exactly frames A then B are output and C is absent.
REQ-033 reset pulsed at out_index=5 -> out_valid=0 immediately; a new frame afterwards is output starting at index 0 with overflow=0.
